// File: rtl/uart_loader.sv
// UART boot loader: receives a little-endian length header plus instruction words and writes them to memory.
// Define LOADER_CHECKSUM_EN to require a 32-bit additive checksum after the image before the CPU is released.
module uart_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int MAX_WORDS    = 1024
) (
    input  logic        CLK100MHZ,
    input  logic        ck_rst,
    input  logic        uart_txd_in,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_run,
    output logic        busy,
    output logic        err
);

    localparam int              CW        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [31:0]     MAX_W     = 32'(MAX_WORDS);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LEN, DATA, SUM, RUN, ERROR} state_t;
`else
    typedef enum logic [2:0] {IDLE, LEN, DATA, RUN, ERROR} state_t;
`endif

    logic          r_sync1;
    logic          r_sync2;
    rx_state_t     r_rxState;
    logic [CW-1:0] r_clkCnt;
    logic [2:0]    r_bitIdx;
    logic [7:0]    r_shift;

    state_t        r_state;
    logic [1:0]    r_byteCnt;
    logic [31:0]   r_word;
    logic [31:0]   r_len;
    logic [29:0]   r_wordIdx;
    logic          r_wrEn;
    logic [31:0]   r_wrAddr;
    logic [31:0]   r_wrData;
    logic          r_cpuRun;
    logic          r_busy;
    logic          r_err;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]   r_sum;
`endif

    logic          w_bitTick;
    logic          w_byteValid;
    logic          w_frameErr;
    logic [31:0]   w_fullWord;

    // The serial line is asynchronous; it idles high so the synchronizer resets to 1.
    always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
        if (!ck_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= uart_txd_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_bitTick   = (r_clkCnt == BIT_LAST);
    assign w_byteValid = (r_rxState == RX_STOP) && w_bitTick && r_sync2;
    assign w_frameErr  = (r_rxState == RX_STOP) && w_bitTick && !r_sync2;
    assign w_fullWord  = {r_shift, r_word[23:0]};

    always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
        if (!ck_rst) begin
            r_rxState <= RX_IDLE;
            r_clkCnt  <= '0;
            r_bitIdx  <= '0;
            r_shift   <= '0;
        end else begin
            case (r_rxState)
                RX_IDLE: begin
                    r_clkCnt <= '0;
                    if (!r_sync2)
                        r_rxState <= RX_START;
                end
                // Half a bit into the start bit: a high line means it was only a glitch.
                RX_START: begin
                    if (r_clkCnt == HALF_LAST) begin
                        r_clkCnt  <= '0;
                        r_bitIdx  <= '0;
                        r_rxState <= r_sync2 ? RX_IDLE : RX_DATA;
                    end else begin
                        r_clkCnt <= r_clkCnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (w_bitTick) begin
                        r_clkCnt <= '0;
                        r_shift  <= {r_sync2, r_shift[7:1]};
                        r_bitIdx <= r_bitIdx + 3'd1;
                        if (r_bitIdx == 3'd7)
                            r_rxState <= RX_STOP;
                    end else begin
                        r_clkCnt <= r_clkCnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (w_bitTick) begin
                        r_clkCnt  <= '0;
                        r_rxState <= RX_IDLE;
                    end else begin
                        r_clkCnt <= r_clkCnt + 1'b1;
                    end
                end
                default: r_rxState <= RX_IDLE;
            endcase
        end
    end

    // Byte k of every header/data/checksum word lands in bits [8k+7:8k].
    always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
        if (!ck_rst) begin
            r_state   <= IDLE;
            r_byteCnt <= '0;
            r_word    <= '0;
            r_len     <= '0;
            r_wordIdx <= '0;
            r_wrEn    <= 1'b0;
            r_wrAddr  <= '0;
            r_wrData  <= '0;
            r_cpuRun  <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_sum     <= '0;
`endif
        end else begin
            r_wrEn <= 1'b0;
            if (w_frameErr && (r_state != RUN)) begin
                r_state  <= ERROR;
                r_err    <= 1'b1;
                r_busy   <= 1'b0;
                r_cpuRun <= 1'b0;
            end else if (w_byteValid && (r_state != RUN) && (r_state != ERROR)) begin
                r_byteCnt <= r_byteCnt + 2'd1;
                r_word[{r_byteCnt, 3'b000} +: 8] <= r_shift;
                case (r_state)
                    IDLE: begin
                        r_state <= LEN;
                        r_busy  <= 1'b1;
                    end
                    LEN: begin
                        if (r_byteCnt == 2'd3) begin
                            r_len     <= w_fullWord;
                            r_wordIdx <= '0;
                            if (w_fullWord == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                                r_state  <= SUM;
`else
                                r_state  <= RUN;
                                r_busy   <= 1'b0;
                                r_cpuRun <= 1'b1;
`endif
                            end else if (w_fullWord > MAX_W) begin
                                r_state <= ERROR;
                                r_busy  <= 1'b0;
                                r_err   <= 1'b1;
                            end else begin
                                r_state <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (r_byteCnt == 2'd3) begin
                            r_wrEn    <= 1'b1;
                            r_wrAddr  <= {r_wordIdx, 2'b00};
                            r_wrData  <= w_fullWord;
                            r_wordIdx <= r_wordIdx + 30'd1;
`ifdef LOADER_CHECKSUM_EN
                            r_sum     <= r_sum + w_fullWord;
`endif
                            if ({2'b00, r_wordIdx} == r_len - 32'd1) begin
`ifdef LOADER_CHECKSUM_EN
                                r_state  <= SUM;
`else
                                r_state  <= RUN;
                                r_busy   <= 1'b0;
                                r_cpuRun <= 1'b1;
`endif
                            end
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    SUM: begin
                        if (r_byteCnt == 2'd3) begin
                            r_busy <= 1'b0;
                            if (w_fullWord == r_sum) begin
                                r_state  <= RUN;
                                r_cpuRun <= 1'b1;
                            end else begin
                                r_state <= ERROR;
                                r_err   <= 1'b1;
                            end
                        end
                    end
`endif
                    default: r_state <= r_state;
                endcase
            end
        end
    end

    assign wr_en   = r_wrEn;
    assign wr_addr = r_wrAddr;
    assign wr_data = r_wrData;
    assign cpu_run = r_cpuRun;
    assign busy    = r_busy;
    assign err     = r_err;

endmodule

// File: tb/tb_uart_loader.sv
// Directed testbench for uart_loader: drives UART frames and checks memory writes and status flags.
// Sends the trailing checksum words when built with LOADER_CHECKSUM_EN.
module tb_uart_loader;

    localparam int CLKS   = 16;
    localparam int CLK_NS = 10;
    localparam int BIT_NS = CLKS * CLK_NS;

    logic        clk;
    logic        rstN;
    logic        rxLine;
    logic        wrEn;
    logic [31:0] wrAddr;
    logic [31:0] wrData;
    logic        cpuRun;
    logic        busyOut;
    logic        errOut;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] wrQ[$];

    uart_loader #(.CLKS_PER_BIT(CLKS), .MAX_WORDS(1024)) dut (
        .CLK100MHZ  (clk),
        .ck_rst     (rstN),
        .uart_txd_in(rxLine),
        .wr_en      (wrEn),
        .wr_addr    (wrAddr),
        .wr_data    (wrData),
        .cpu_run    (cpuRun),
        .busy       (busyOut),
        .err        (errOut)
    );

    initial clk = 1'b0;
    always #(CLK_NS / 2) clk = ~clk;

    // Every cycle with wr_en high records one write, so a stretched strobe shows up as extra writes.
    always @(negedge clk) begin
        if (rstN && wrEn)
            wrQ.push_back({wrAddr, wrData});
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic stopOk);
        rxLine = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            rxLine = b[i];
            #(BIT_NS);
        end
        rxLine = stopOk;
        #(BIT_NS);
        rxLine = 1'b1;
        if (!stopOk)
            #(BIT_NS);
    endtask

    task automatic sendWord(input logic [31:0] w);
        for (int k = 0; k < 4; k++)
            applyStimulus(w[8*k +: 8], 1'b1);
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        rstN = 1'b0;
        #1;
        wrQ.delete();
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rstN   = 1'b0;
        rxLine = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_wr_en",   32'(wrEn),    32'd0);
        checkOutput("rst_wr_addr", wrAddr,       32'd0);
        checkOutput("rst_wr_data", wrData,       32'd0);
        checkOutput("rst_cpu_run", 32'(cpuRun),  32'd0);
        checkOutput("rst_busy",    32'(busyOut), 32'd0);
        checkOutput("rst_err",     32'(errOut),  32'd0);
        rstN = 1'b1;
        repeat (4) @(negedge clk);

        $display("[TB] two-word image");
        sendWord(32'd2);
        settle();
        checkOutput("img2_busy_data", 32'(busyOut), 32'd1);
        sendWord(32'h0010_0513);
        sendWord(32'h0020_0593);
`ifdef LOADER_CHECKSUM_EN
        sendWord(32'h0030_0AA6);
`endif
        settle();
        checkOutput("img2_wr_count", 32'(wrQ.size()), 32'd2);
        checkOutput("img2_addr0",    wrQ[0][63:32],   32'h0000_0000);
        checkOutput("img2_data0",    wrQ[0][31:0],    32'h0010_0513);
        checkOutput("img2_addr1",    wrQ[1][63:32],   32'h0000_0004);
        checkOutput("img2_data1",    wrQ[1][31:0],    32'h0020_0593);
        checkOutput("img2_hold_addr", wrAddr,         32'h0000_0004);
        checkOutput("img2_hold_data", wrData,         32'h0020_0593);
        checkOutput("img2_cpu_run",  32'(cpuRun),     32'd1);
        checkOutput("img2_busy",     32'(busyOut),    32'd0);
        checkOutput("img2_err",      32'(errOut),     32'd0);
        sendWord(32'hDEAD_BEEF);
        settle();
        checkOutput("run_ignore_wr", 32'(wrQ.size()), 32'd2);
        checkOutput("run_stays",     32'(cpuRun),     32'd1);

        $display("[TB] zero-length image");
        doReset();
        checkOutput("rst2_cpu_run", 32'(cpuRun), 32'd0);
        sendWord(32'd0);
`ifdef LOADER_CHECKSUM_EN
        sendWord(32'd0);
`endif
        settle();
        checkOutput("len0_wr_count", 32'(wrQ.size()), 32'd0);
        checkOutput("len0_cpu_run",  32'(cpuRun),     32'd1);
        checkOutput("len0_err",      32'(errOut),     32'd0);

        $display("[TB] oversize length 1025");
        doReset();
        sendWord(32'd1025);
        settle();
        checkOutput("big_err",      32'(errOut),     32'd1);
        checkOutput("big_cpu_run",  32'(cpuRun),     32'd0);
        checkOutput("big_busy",     32'(busyOut),    32'd0);
        sendWord(32'h1234_5678);
        settle();
        checkOutput("big_wr_count", 32'(wrQ.size()), 32'd0);

        $display("[TB] exactly MAX_WORDS is accepted");
        doReset();
        sendWord(32'd1024);
        settle();
        checkOutput("max_err",  32'(errOut),  32'd0);
        checkOutput("max_busy", 32'(busyOut), 32'd1);

        $display("[TB] framing error during data");
        doReset();
        sendWord(32'd2);
        sendWord(32'hCAFE_F00D);
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h22, 1'b0);
        settle();
        checkOutput("ferr_err",      32'(errOut),     32'd1);
        checkOutput("ferr_cpu_run",  32'(cpuRun),     32'd0);
        checkOutput("ferr_wr_count", 32'(wrQ.size()), 32'd1);
        checkOutput("ferr_data0",    wrQ[0][31:0],    32'hCAFE_F00D);
        sendWord(32'h0102_0304);
        sendWord(32'h0506_0708);
        settle();
        checkOutput("ferr_no_more_wr", 32'(wrQ.size()), 32'd1);
        checkOutput("ferr_sticky",     32'(errOut),     32'd1);

        $display("[TB] glitch on idle line");
        doReset();
        rxLine = 1'b0;
        #(BIT_NS / 4);
        rxLine = 1'b1;
        #(2 * BIT_NS);
        checkOutput("glitch_busy", 32'(busyOut), 32'd0);
        sendWord(32'd1);
        sendWord(32'h1234_5678);
`ifdef LOADER_CHECKSUM_EN
        sendWord(32'h1234_5678);
`endif
        settle();
        checkOutput("glitch_wr_count", 32'(wrQ.size()), 32'd1);
        checkOutput("glitch_addr0",    wrQ[0][63:32],   32'h0000_0000);
        checkOutput("glitch_data0",    wrQ[0][31:0],    32'h1234_5678);
        checkOutput("glitch_cpu_run",  32'(cpuRun),     32'd1);

        $display("[TB] reset mid-transfer");
        doReset();
        sendWord(32'd2);
        sendWord(32'hAABB_CCDD);
        applyStimulus(8'h55, 1'b1);
        settle();
        checkOutput("mid_first_wr", 32'(wrQ.size()), 32'd1);
        @(negedge clk);
        rstN = 1'b0;
        #1;
        checkOutput("mid_rst_busy",    32'(busyOut), 32'd0);
        checkOutput("mid_rst_wr_addr", wrAddr,       32'd0);
        checkOutput("mid_rst_wr_data", wrData,       32'd0);
        wrQ.delete();
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        repeat (4) @(negedge clk);
        sendWord(32'd1);
        sendWord(32'hDEAD_BEEF);
`ifdef LOADER_CHECKSUM_EN
        sendWord(32'hDEAD_BEEF);
`endif
        settle();
        checkOutput("mid_wr_count", 32'(wrQ.size()), 32'd1);
        checkOutput("mid_addr0",    wrQ[0][63:32],   32'h0000_0000);
        checkOutput("mid_data0",    wrQ[0][31:0],    32'hDEAD_BEEF);
        checkOutput("mid_cpu_run",  32'(cpuRun),     32'd1);
        checkOutput("mid_err",      32'(errOut),     32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
